// File: rtl/cmd_sequencer.sv
// cmd_sequencer: buffers 8-bit commands from a valid/ready stream and replays
// them as single-cycle register writes into signal_generator. The address
// field is cmd[7:5] and the payload is cmd[4:0]. Address 3'b111 is a timed
// WAIT of payload*WAIT_TICK cycles.
// Optional build macro CMD_SEQUENCER_FLUSH_EN adds a synchronous flush input.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready to pop the FIFO head
// STROBE | write_strobe is high for this single cycle
// GAP    | enforced idle spacing after a strobe (STROBE_GAP cycles)
// WAIT   | timed WAIT command in progress (n*WAIT_TICK cycles)
module cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WAIT_TICK  = 256,
    parameter int STROBE_GAP = 1
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef CMD_SEQUENCER_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic                          cmd_valid,
    input  logic [7:0]                    cmd_data,
    output logic                          cmd_ready,
    output logic                          write_strobe,
    output logic [2:0]                    address,
    output logic [4:0]                    data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    // Sized so a WAIT with n=31 fits; the GAP count shares this counter.
    localparam int CW = $clog2(31 * WAIT_TICK + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    localparam logic [CW-1:0] GAP_LOAD = (STROBE_GAP > 0) ? CW'(STROBE_GAP - 1) : '0;

    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [LW-1:0] level;
    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          flushNow;
    logic          push;
    logic          pop;
    logic [7:0]    headCmd;
    logic [CW-1:0] waitLoad;

`ifdef CMD_SEQUENCER_FLUSH_EN
    assign flushNow = flush;
`else
    assign flushNow = 1'b0;
`endif

    // ready depends only on the registered occupancy, so a full FIFO refuses
    // a push even when the FSM pops in the same cycle
    assign cmd_ready  = (level != LW'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready && !flushNow;
    assign pop        = (state == ST_IDLE) && (level != '0) && !flushNow;
    assign headCmd    = fifoMem[rdPtr];
    assign waitLoad   = CW'(headCmd[4:0]) * CW'(WAIT_TICK) - CW'(1);
    assign busy       = (level != '0) || (state != ST_IDLE);
    assign fifo_level = level;

    // FIFO storage; contents need no reset because occupancy guards reads
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (flushNow) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Command execution FSM with the shared GAP/WAIT down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            write_strobe <= 1'b0;
            address      <= '0;
            data         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (headCmd[7:5] != 3'b111) begin
                            address      <= headCmd[7:5];
                            data         <= headCmd[4:0];
                            write_strobe <= 1'b1;
                            state        <= ST_STROBE;
                        end else if (headCmd[4:0] != 5'd0) begin
                            count <= waitLoad;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_STROBE: begin
                    write_strobe <= 1'b0;
                    if (flushNow || (STROBE_GAP == 0)) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= GAP_LOAD;
                        state <= ST_GAP;
                    end
                end
                ST_GAP, ST_WAIT: begin
                    if (flushNow || (count == '0)) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    write_strobe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer (default parameters). A transaction-
// level model predicts, for each accepted command, the edge at which it is
// popped from the time the executor becomes free, and from that the strobe
// edges, held address/data, FIFO occupancy, ready and busy every cycle.
module tb_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TICK  = 256;
    localparam int GAP   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       write_strobe;
    logic [2:0] address;
    logic [4:0] data;
    logic       busy;
    logic [2:0] fifo_level;
`ifdef CMD_SEQUENCER_FLUSH_EN
    logic       flush = 1'b0;
`endif

    cmd_sequencer #(.FIFO_DEPTH(DEPTH), .WAIT_TICK(TICK), .STROBE_GAP(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CMD_SEQUENCER_FLUSH_EN
        .flush       (flush),
`endif
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .write_strobe(write_strobe),
        .address     (address),
        .data        (data),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int edgeNum = 0;

    // model state
    int level = 0;
    int tailFree = 0;
    int expAddr = 0;
    int expData = 0;
    int accAt[int];
    int popAt[int];
    int writeAt[int];

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edgeNum);
    endtask

    // Command accepted at edge a: schedule its pop at the first edge the
    // executor is free and the entry is visible.
    task automatic modelAccept(input int a, input logic [7:0] d);
        int p;
        int n;
        p = (a + 1 > tailFree) ? a + 1 : tailFree;
        accAt[a] = 1;
        popAt[p] = 1;
        n = int'(d[4:0]);
        if (d[7:5] != 3'b111) begin
            writeAt[p] = int'(d);
            tailFree = p + 2 + GAP;
        end else if (n > 0) begin
            tailFree = p + n * TICK + 1;
        end else begin
            tailFree = p + 1;
        end
    endtask

    task automatic checkOutputs();
        int e;
        bit strobeExp;
        e = edgeNum;
        level += (accAt.exists(e) ? 1 : 0) - (popAt.exists(e) ? 1 : 0);
        strobeExp = writeAt.exists(e);
        if (strobeExp) begin
            expAddr = writeAt[e] >> 5;
            expData = writeAt[e] & 31;
        end
        checkVal("write_strobe", int'(write_strobe), int'(strobeExp));
        checkVal("address", int'(address), expAddr);
        checkVal("data", int'(data), expData);
        checkVal("fifo_level", int'(fifo_level), level);
        checkVal("cmd_ready", int'(cmd_ready), int'(level < DEPTH));
        checkVal("busy", int'(busy), int'((level > 0) || (e < tailFree - 1)));
    endtask

    // one clock: drive at the negedge, advance, then check at the next negedge
    task automatic cycle(input bit v, input logic [7:0] d);
        cmd_valid = v;
        cmd_data  = d;
        if (v && level < DEPTH) modelAccept(edgeNum + 1, d);
        @(posedge clk);
        edgeNum++;
        @(negedge clk);
        checkOutputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic doReset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        #1;
        checkVal("rst_strobe", int'(write_strobe), 0);
        checkVal("rst_address", int'(address), 0);
        checkVal("rst_data", int'(data), 0);
        checkVal("rst_level", int'(fifo_level), 0);
        checkVal("rst_ready", int'(cmd_ready), 1);
        checkVal("rst_busy", int'(busy), 0);
        accAt.delete();
        popAt.delete();
        writeAt.delete();
        level = 0;
        tailFree = 0;
        expAddr = 0;
        expData = 0;
        @(posedge clk);
        @(posedge clk);
        edgeNum += 2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        doReset();

        // single write: strobe one edge after acceptance
        cycle(1'b1, 8'h45);
        idle(6);

        // park the executor in a WAIT so four writes fill the FIFO
        cycle(1'b1, 8'hE1);
        cycle(1'b1, 8'h41);
        cycle(1'b1, 8'h62);
        cycle(1'b1, 8'h83);
        cycle(1'b1, 8'hA4);
        checkVal("full_ready", int'(cmd_ready), 0);
        cycle(1'b1, 8'hC6);
        idle(TICK + 20);

        // WAIT n=3 then a write
        cycle(1'b1, 8'hE3);
        cycle(1'b1, 8'h21);
        idle(3 * TICK + 10);

        // WAIT n=0 is a one-pop no-op
        cycle(1'b1, 8'hE0);
        cycle(1'b1, 8'h01);
        idle(6);

        // reset 100 cycles into a WAIT n=31 with two entries queued
        cycle(1'b1, 8'hFF);
        cycle(1'b1, 8'h45);
        cycle(1'b1, 8'h66);
        idle(98);
        doReset();
        idle(20);

        // randomized traffic, mostly writes with occasional short WAITs
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            if ($urandom_range(15) == 0) begin
                d = {3'b111, 5'($urandom_range(2))};
            end else begin
                d = {3'($urandom_range(6)), 5'($urandom_range(31))};
            end
            cycle(1'($urandom_range(1)), d);
        end
        idle(600);

`ifdef CMD_SEQUENCER_FLUSH_EN
        begin
            bit seen;
            doReset();
            cmd_valid = 1'b1;
            cmd_data  = 8'h41;
            repeat (3) @(negedge clk);
            cmd_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (write_strobe) seen = 1'b1;
                else @(negedge clk);
            end
            checkVal("flush_first_strobe", int'(seen), 1);
            @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            checkVal("flush_level", int'(fifo_level), 0);
            checkVal("flush_busy", int'(busy), 0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checkVal("flush_no_strobe", int'(write_strobe), 0);
            end
            checkVal("flush_address", int'(address), 2);
            checkVal("flush_data", int'(data), 1);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
